// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler. Double-buffered: one word can wait on the
// valid/ready output while the next word fills. Dropped bits set a sticky overflow flag.
module bit_deserializer #(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [W-1:0]         word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic [$clog2(W)-1:0] fill_cnt
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic {FILL, PEND} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   sr, sr_nxt, sr_shift;
  logic [CW-1:0]  cnt_nxt;
  logic [W-1:0]   word_nxt;
  logic           wv_nxt;
  logic           ovf_nxt;
  logic           slot_free;
  logic           accept;

  assign bit_ready = (state == FILL);
  assign slot_free = !word_valid || word_ready;
  assign accept    = bit_valid && bit_ready;
  assign sr_shift  = MSB_FIRST ? {sr[W-2:0], bit_in} : {bit_in, sr[W-1:1]};

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = fill_cnt;
    word_nxt  = word_out;
    // a transfer empties the slot unless a new word is loaded below
    wv_nxt    = word_valid && !word_ready;
    ovf_nxt   = ovf;

    if (bit_valid && !bit_ready) begin
      ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end

    unique case (state)
      FILL: begin
        if (accept) begin
          sr_nxt = sr_shift;
          if (fill_cnt == CW'(W - 1)) begin
            cnt_nxt = '0;
            if (slot_free) begin
              word_nxt = sr_shift;
              wv_nxt   = 1'b1;
            end else begin
              state_nxt = PEND;
            end
          end else begin
            cnt_nxt = fill_cnt + CW'(1);
          end
        end
      end
      PEND: begin
        if (slot_free) begin
          word_nxt  = sr;
          wv_nxt    = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      sr         <= '0;
      fill_cnt   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      fill_cnt   <= cnt_nxt;
      word_out   <= word_nxt;
      word_valid <= wv_nxt;
      ovf        <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: both bit orders driven in parallel, checked against a
// word-level buffer model plus a scoreboard popped on each output handshake.
module tb_bit_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0, ovf_clr = 1'b0;

  logic          bit_ready_m, word_valid_m, ovf_m;
  logic [W-1:0]  word_out_m;
  logic [CW-1:0] fill_cnt_m;
  logic          bit_ready_l, word_valid_l, ovf_l;
  logic [W-1:0]  word_out_l;
  logic [CW-1:0] fill_cnt_l;

  bit_deserializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_m),
    .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .ovf(ovf_m), .ovf_clr(ovf_clr), .fill_cnt(fill_cnt_m)
  );

  bit_deserializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_l),
    .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .ovf(ovf_l), .ovf_clr(ovf_clr), .fill_cnt(fill_cnt_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: words held by the stage (output slot first), partial bit list, sticky flag
  logic [W-1:0] held_m[$], held_l[$], exp_m[$], exp_l[$];
  bit           bits[$];
  bit           r_ovf;
  logic [W-1:0] r_wout_m, r_wout_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (msb) w[W-1-i] = bits[i];
      else     w[i]     = bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    held_m.delete(); held_l.delete();
    exp_m.delete();  exp_l.delete();
    bits.delete();
    r_ovf    = 1'b0;
    r_wout_m = '0;
    r_wout_l = '0;
  endtask

  task automatic check_state();
    chk("bit_ready",    bit_ready_m,  held_m.size() < 2);
    chk("word_valid",   word_valid_m, held_m.size() != 0);
    chk("ovf",          ovf_m,        r_ovf);
    chk("fill_cnt",     fill_cnt_m,   bits.size());
    chk("word_out",     word_out_m,   r_wout_m);
    chk("lsb.word_valid", word_valid_l, held_l.size() != 0);
    chk("lsb.fill_cnt",   fill_cnt_l,   bits.size());
    chk("lsb.word_out",   word_out_l,   r_wout_l);
    chk("lsb.ovf",        ovf_l,        r_ovf);
  endtask

  // Called just after a rising edge: drives inputs, advances the model, checks after next edge
  task automatic step(input bit b, input bit v, input bit wr, input bit clr);
    bit rdy, xfer;
    bit_in = b; bit_valid = v; word_ready = wr; ovf_clr = clr;
    rdy  = (held_m.size() < 2);
    xfer = (held_m.size() != 0) && wr;
    if (v && !rdy)  r_ovf = 1'b1;
    else if (clr)   r_ovf = 1'b0;
    if (xfer) begin
      void'(held_m.pop_front());
      void'(held_l.pop_front());
    end
    if (v && rdy) begin
      bits.push_back(b);
      if (bits.size() == int'(W)) begin
        held_m.push_back(pack(1'b1)); exp_m.push_back(pack(1'b1));
        held_l.push_back(pack(1'b0)); exp_l.push_back(pack(1'b0));
        bits.delete();
      end
    end
    if (held_m.size() != 0) begin
      r_wout_m = held_m[0];
      r_wout_l = held_l[0];
    end
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit wr);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, wr, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst.word_valid", word_valid_m, 1'b0);
    chk("rst.word_out",   word_out_m,   '0);
    chk("rst.fill_cnt",   fill_cnt_m,   '0);
    chk("rst.ovf",        ovf_m,        1'b0);
    chk("rst.bit_ready",  bit_ready_m,  1'b1);
    chk("rst.lsb.word_out", word_out_l, '0);
  endtask

  // Scoreboard monitors: one pop per handshake on each output port
  always @(negedge clk) begin
    if (!rst && word_valid_m && word_ready) begin
      total++;
      if (exp_m.size() == 0) begin
        bad++;
        $display("FAIL mon_msb: got word %0h expected no word", word_out_m);
      end else if (word_out_m !== exp_m[0]) begin
        bad++;
        $display("FAIL mon_msb: got %0h expected %0h", word_out_m, exp_m[0]);
        void'(exp_m.pop_front());
      end else begin
        void'(exp_m.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && word_valid_l && word_ready) begin
      total++;
      if (exp_l.size() == 0) begin
        bad++;
        $display("FAIL mon_lsb: got word %0h expected no word", word_out_l);
      end else if (word_out_l !== exp_l[0]) begin
        bad++;
        $display("FAIL mon_lsb: got %0h expected %0h", word_out_l, exp_l[0]);
        void'(exp_l.pop_front());
      end else begin
        void'(exp_l.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] pat;
    model_reset();
    #2;
    check_reset_outputs();
    #10;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_state();

    // Directed word 1,0,1,1,0,0,1,0
    pat = 8'b1011_0010;
    send_word(pat, 1'b1);
    chk("t1.msb_word", word_out_m, 8'hB2);
    chk("t1.lsb_word", word_out_l, 8'h4D);
    chk("t1.valid",    word_valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1.one_cycle", word_valid_m, 1'b0);

    // Stalled output: A5 held, 3C pending, FF dropped
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("t2.pend_ready", bit_ready_m, 1'b0);
    send_word(8'hFF, 1'b0);
    chk("t2.ovf",      ovf_m, 1'b1);
    chk("t2.hold_a5",  word_out_m, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2.then_3c",  word_out_m, 8'h3C);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2.drained", exp_m.size(), 0);

    // Drop and clear together: set wins; clear alone then clears
    send_word(W'($urandom), 1'b0);
    send_word(W'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t3.set_wins", ovf_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3.cleared",  ovf_m, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Full-rate stream, four words
    for (int k = 0; k < 4; k++) send_word(W'($urandom), 1'b1);
    chk("t4.no_ovf", ovf_m, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    bit_valid = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_state();
    send_word(8'h96, 1'b1);
    chk("t5.clean_word", word_out_m, 8'h96);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("end.drained_msb", exp_m.size(), 0);
    chk("end.drained_lsb", exp_l.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
